uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, number of clk cycles per serial bit (100 MHz / 115200 baud); legal range 8..65535.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rx_serial  input  1  asynchronous serial line: idle high, 8N1 frames, LSB first.
REQ-005 rx_byte  output  8  last correctly received byte; holds its value until the next rx_valid.
REQ-006 rx_valid  output  1  one-cycle pulse; rx_byte is new and valid in the same cycle.
REQ-007 frame_error  output  1  one-cycle pulse when a frame's stop bit is sampled low.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 rx_serial SHALL pass through a 2-flop synchronizer, reset value 1; all FSM decisions use only the synchronized value.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-011 A 16-bit cycle counter and a 3-bit bit index SHALL be cleared on every state transition.
REQ-012 IDLE: synchronized line == 0 -> START.
REQ-013 START: at counter == (CLKS_PER_BIT-1)/2 (integer division), line 0 -> DATA; line 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: at counter == CLKS_PER_BIT-1, sample the line into internal shift register bit [bit index], clear the counter, and increment the bit index; sampling bit index 7 -> STOP.
REQ-015 STOP: at counter == CLKS_PER_BIT-1, line 1 -> load rx_byte from the shift register, pulse rx_valid, go to IDLE.
REQ-016 STOP: at counter == CLKS_PER_BIT-1, line 0 -> pulse frame_error, leave rx_byte unchanged, no rx_valid, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: stay until the synchronized line == 1, then go to IDLE; a held-low line (break) SHALL produce exactly one frame_error.
REQ-018 rx_valid and frame_error SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-019 rx_byte SHALL not change while a frame is being received; only the internal shift register updates.
REQ-020 rx_valid SHALL rise 9*CLKS_PER_BIT + (CLKS_PER_BIT-1)/2 + 3 cycles (+/-1) after the rx_serial falling edge of the start bit.
REQ-021 A new start bit arriving in the first cycle after the STOP sample SHALL be accepted (back-to-back frames, no idle gap required).
REQ-022 The bit index SHALL wrap 7 -> 0 only through the transition out of DATA, never mid-frame.

Reset
REQ-023 On rst high, regardless of clk, the block SHALL immediately force the following values: state IDLE, counters 0, shift register 0, rx_byte 0x00, rx_valid 0, frame_error 0, busy 0, synchronizer flops 1.
REQ-024 If rst asserts mid-frame, the partial frame SHALL be discarded with no rx_valid or frame_error pulse.
REQ-025 After rst deasserts, the next valid falling edge on rx_serial SHALL start a new frame normally.

Verification (CLKS_PER_BIT=16)
REQ-026 Test 1: send frame 0x55 -> exactly one rx_valid pulse, rx_byte=0x55, 155 +/-1 cycles after the start edge; frame_error stays 0.
REQ-027 Test 2: send back-to-back frames 0xA5, 0x00, 0xFF with no idle gap -> three rx_valid pulses in order with those values.
REQ-028 Test 3: drive a 4-cycle low glitch on an idle line -> no rx_valid, no frame_error, busy returns to 0 within 12 cycles.
REQ-029 Test 4: send frame 0x3C with stop bit 0, then hold the line low for 100 cycles, then release -> one frame_error pulse, rx_byte keeps its previous value, a following 0x81 frame is received correctly.
REQ-030 Test 5: assert rst during data bit 4 of frame 0x7E -> outputs take their reset values immediately, no pulse; a following 0x12 frame yields rx_byte=0x12.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// one-cycle rx_valid / frame_error pulses and a held rx_byte register.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [7:0]  shift, shift_next;
  logic [7:0]  rx_byte_next;
  logic        rx_valid_next, frame_error_next;
  logic        sync1, sync2;
  logic        line;

  // Reset to 1 so an idle (high) line never looks like a start bit after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_serial;
      sync2 <= sync1;
    end
  end

  assign line = sync2;
  assign busy = (state != IDLE);

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      rx_byte     <= rx_byte_next;
      rx_valid    <= rx_valid_next;
      frame_error <= frame_error_next;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt + 16'd1;
    bit_idx_next     = bit_idx;
    shift_next       = shift;
    rx_byte_next     = rx_byte;
    rx_valid_next    = 1'b0;
    frame_error_next = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (!line) state_next = START;
      end
      START: begin
        if (cnt == HALF_BIT) state_next = line ? IDLE : DATA;
      end
      DATA: begin
        if (cnt == FULL_BIT) begin
          shift_next[bit_idx] = line;
          bit_idx_next        = bit_idx + 3'd1;
          cnt_next            = '0;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_BIT) begin
          if (line) begin
            rx_byte_next  = shift;
            rx_valid_next = 1'b1;
            state_next    = IDLE;
          end else begin
            frame_error_next = 1'b1;
            state_next       = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A break keeps us here, so it reports only the single frame_error above.
        cnt_next = '0;
        if (line) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state) begin
      cnt_next     = '0;
      bit_idx_next = '0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_error, busy;

  int errors = 0;
  int checks = 0;

  int         cyc = 0;
  int         vld_cnt = 0;
  int         fe_cnt = 0;
  int         overlap = 0;
  int         bad_change = 0;
  int         last_vld_cyc = 0;
  logic [7:0] prev_byte = 8'h00;
  logic [7:0] got_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_serial   (rx_serial),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe outputs on the falling edge, away from the DUT's update edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      vld_cnt++;
      got_q.push_back(rx_byte);
      last_vld_cyc = cyc;
    end
    if (frame_error) fe_cnt++;
    if (rx_valid && frame_error) overlap++;
    if (!rst && !rx_valid && rx_byte !== prev_byte) bad_change++;
    prev_byte = rx_byte;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = data[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  int v0, f0, c0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_rx_byte", 32'(rx_byte), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_error", 32'(frame_error), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    @(negedge clk);

    // Test 1: single 0x55 frame and its latency
    v0 = vld_cnt; f0 = fe_cnt; c0 = cyc;
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (60) @(negedge clk);
        #1;
        check("t1_busy_mid", 32'(busy), 32'h1);
        check("t1_byte_held_mid", 32'(rx_byte), 32'h00);
      end
    join
    idle(20);
    check("t1_valid_count", 32'(vld_cnt - v0), 32'd1);
    check("t1_rx_byte", 32'(rx_byte), 32'h55);
    check("t1_latency", 32'(last_vld_cyc - c0), 32'd155);
    check("t1_no_ferr", 32'(fe_cnt - f0), 32'd0);
    check("t1_busy_idle", 32'(busy), 32'h0);

    // Test 2: back-to-back frames, no idle gap
    got_q.delete();
    v0 = vld_cnt; f0 = fe_cnt;
    @(negedge clk);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("t2_valid_count", 32'(vld_cnt - v0), 32'd3);
    check("t2_byte0", 32'(got_q.size() > 0 ? got_q[0] : 8'hxx), 32'hA5);
    check("t2_byte1", 32'(got_q.size() > 1 ? got_q[1] : 8'hxx), 32'h00);
    check("t2_byte2", 32'(got_q.size() > 2 ? got_q[2] : 8'hxx), 32'hFF);
    check("t2_no_ferr", 32'(fe_cnt - f0), 32'd0);

    // Test 3: 4-cycle glitch on an idle line
    v0 = vld_cnt; f0 = fe_cnt;
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (4) @(negedge clk);
    rx_serial = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("t3_busy_during", 32'(busy), 32'h1);
    repeat (6) @(negedge clk);
    #1;
    check("t3_busy_cleared", 32'(busy), 32'h0);
    idle(20);
    check("t3_no_valid", 32'(vld_cnt - v0), 32'd0);
    check("t3_no_ferr", 32'(fe_cnt - f0), 32'd0);
    check("t3_byte_kept", 32'(rx_byte), 32'hFF);

    // Test 4: bad stop bit followed by a 100-cycle break, then a good frame
    v0 = vld_cnt; f0 = fe_cnt;
    @(negedge clk);
    send_frame(8'h3C, 1'b0);
    repeat (100) @(negedge clk);
    #1;
    check("t4_busy_in_break", 32'(busy), 32'h1);
    idle(20);
    check("t4_one_ferr", 32'(fe_cnt - f0), 32'd1);
    check("t4_no_valid", 32'(vld_cnt - v0), 32'd0);
    check("t4_byte_kept", 32'(rx_byte), 32'hFF);
    check("t4_busy_after", 32'(busy), 32'h0);
    v0 = vld_cnt; f0 = fe_cnt;
    @(negedge clk);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("t4_next_valid", 32'(vld_cnt - v0), 32'd1);
    check("t4_next_byte", 32'(rx_byte), 32'h81);
    check("t4_next_no_ferr", 32'(fe_cnt - f0), 32'd0);

    // Test 5: reset during data bit 4 of 0x7E, then a 0x12 frame
    v0 = vld_cnt; f0 = fe_cnt;
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = 1'(8'h7E >> i);
      repeat (CPB) @(negedge clk);
    end
    rx_serial = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_byte", 32'(rx_byte), 32'h00);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_valid", 32'(rx_valid), 32'h0);
    check("t5_rst_ferr", 32'(frame_error), 32'h0);
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(10);
    check("t5_no_valid", 32'(vld_cnt - v0), 32'd0);
    check("t5_no_ferr", 32'(fe_cnt - f0), 32'd0);
    @(negedge clk);
    send_frame(8'h12, 1'b1);
    idle(20);
    check("t5_next_valid", 32'(vld_cnt - v0), 32'd1);
    check("t5_next_byte", 32'(rx_byte), 32'h12);

    // Whole-run properties
    check("pulse_overlap", 32'(overlap), 32'd0);
    check("byte_changed_without_valid", 32'(bad_change), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
